// File: rtl/seq_detect_ctrl.sv
// Frame controller: serializes valid/ready words MSB-first into a programmable pattern matcher (SEQ_DETECT_CTRL_OVERLAP_EN enables overlapping matches).
// Latency: a word's MSB is scanned one cycle after acceptance; match_pulse/match_count are registered; done follows the last bit by two edges.
// Backpressure: in_ready is high in IDLE or on a non-last word's final bit, and never depends on in_valid.
module seq_detect_ctrl #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 8,
  parameter int LEN_W  = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_count,
  output logic              busy,
  output logic              done
);

  localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(DATA_W - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
`ifdef SEQ_DETECT_CTRL_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic               last_q, last_d;
  logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [PAT_W-1:0]   hist_q, hist_d;
  logic [LEN_W-1:0]   vcnt_q, vcnt_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               pulse_q, pulse_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;

  logic [PAT_W-1:0]   len_mask;
  logic [PAT_W-1:0]   hist_shift;
  logic [LEN_W-1:0]   vcnt_inc;
  logic               hit;
  logic               accept;

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  // Match is judged on the history as it will look after this cycle's shift.
  always_comb begin
    hist_shift = (hist_q << 1) | PAT_W'(word_q[DATA_W-1]);
    vcnt_inc   = (vcnt_q == LEN_MAX) ? vcnt_q : vcnt_q + 1'b1;
    hit        = (((hist_shift ^ pat_q) & len_mask) == '0) && (vcnt_inc >= len_q);
    in_ready   = (state_q == IDLE) ||
                 ((state_q == SHIFT) && (bit_cnt_q == BIT_LAST) && !last_q);
    accept     = in_valid && in_ready;
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    last_d    = last_q;
    bit_cnt_d = bit_cnt_q;
    hist_d    = hist_q;
    vcnt_d    = vcnt_q;
    pat_d     = pat_q;
    len_d     = len_q;
    pulse_d   = 1'b0;
    cnt_d     = cnt_q;
    done_d    = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (cfg_load) begin
          pat_d = cfg_pattern;
          if (cfg_len == '0)          len_d = LEN_W'(1);
          else if (cfg_len > LEN_MAX) len_d = LEN_MAX;
          else                        len_d = cfg_len;
        end
        if (accept) begin
          word_d    = in_data;
          last_d    = in_last;
          bit_cnt_d = '0;
          hist_d    = '0;
          vcnt_d    = '0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        hist_d    = hist_shift;
        vcnt_d    = (hit && !OVERLAP) ? '0 : vcnt_inc;
        pulse_d   = hit;
        if (hit && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        word_d    = word_q << 1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BIT_LAST) begin
          if (accept) begin
            word_d    = in_data;
            last_d    = in_last;
            bit_cnt_d = '0;
          end else if (last_q) begin
            state_d = DONE;
          end else begin
            // Frame abandoned without a last word: the next word starts fresh.
            hist_d  = '0;
            vcnt_d  = '0;
            state_d = IDLE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      word_q    <= '0;
      last_q    <= 1'b0;
      bit_cnt_q <= '0;
      hist_q    <= '0;
      vcnt_q    <= '0;
      pat_q     <= '0;
      len_q     <= LEN_W'(1);
      pulse_q   <= 1'b0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      last_q    <= last_d;
      bit_cnt_q <= bit_cnt_d;
      hist_q    <= hist_d;
      vcnt_q    <= vcnt_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      pulse_q   <= pulse_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
    end
  end

  assign match_pulse = pulse_q;
  assign match_count = cnt_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed and random frames checked against a bit-stream pattern-search model of seq_detect_ctrl.
module tb_seq_detect_ctrl;
  localparam int DATA_W = 8;
  localparam int PAT_W  = 4;
  localparam int CNT_W  = 4;
  localparam int LEN_W  = 3;
  localparam int CNT_SAT = (1 << CNT_W) - 1;
`ifdef SEQ_DETECT_CTRL_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic [PAT_W-1:0]  cfg_pattern;
  logic [LEN_W-1:0]  cfg_len;
  logic              cfg_load;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic              match_pulse;
  logic [CNT_W-1:0]  match_count;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  seq_detect_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_load(cfg_load), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .match_pulse(match_pulse), .match_count(match_count),
    .busy(busy), .done(done)
  );

  int vectors = 0;
  int miscompares = 0;

  int m_pat;
  int m_len;
  logic [DATA_W-1:0] fw[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_len(input int l);
    if (l == 0) return 1;
    if (l > PAT_W) return PAT_W;
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_load    = 1'b1;
    step();
    cfg_load    = 1'b0;
    m_pat       = int'(p);
    m_len       = eff_len(int'(l));
  endtask

  // Scans the whole frame as one bit stream; a match needs len bits since the
  // previous match when overlapping is off.
  task automatic run_frame(input string tag, input bit glitch, output int final_cnt);
    bit bits[$];
    bit ep[$];
    int ec[$];
    int cnt = 0;
    int lastm = -1;
    int n = fw.size();
    for (int w = 0; w < n; w++)
      for (int b = DATA_W - 1; b >= 0; b--) bits.push_back(fw[w][b]);
    for (int k = 0; k < bits.size(); k++) begin
      int avail;
      bit h;
      avail = OVERLAP ? (k + 1) : (k - lastm);
      h = (avail >= m_len);
      if (h)
        for (int j = 0; j < m_len; j++)
          if (bits[k-j] != bit'((m_pat >> j) & 1)) h = 0;
      if (h) begin
        lastm = k;
        if (cnt < CNT_SAT) cnt++;
      end
      ep.push_back(h);
      ec.push_back(cnt);
    end

    in_valid = 1'b1;
    in_data  = fw[0];
    in_last  = (n == 1);
    chk({tag, "_rdy_idle"}, in_ready, 1);
    step();
    if (n > 1) begin
      in_data = fw[1];
      in_last = (n == 2);
    end else begin
      in_valid = 1'b0;
    end
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < DATA_W; b++) begin
        int k;
        k = w * DATA_W + b;
        if (glitch && w == 0 && b == 2) begin
          cfg_pattern = ~PAT_W'(m_pat);
          cfg_len     = LEN_W'($urandom_range(0, 7));
          cfg_load    = 1'b1;
        end
        chk({tag, "_rdy"}, in_ready, (b == DATA_W - 1 && w < n - 1));
        step();
        cfg_load = 1'b0;
        if (b == DATA_W - 1 && w < n - 1) begin
          if (w + 2 < n) begin
            in_data = fw[w+2];
            in_last = (w + 2 == n - 1);
          end else begin
            in_valid = 1'b0;
          end
        end
        chk({tag, "_pulse"}, match_pulse, ep[k]);
        chk({tag, "_cnt"}, match_count, ec[k]);
      end
    end
    chk({tag, "_done_busy"}, busy, 1);
    chk({tag, "_done_rdy"}, in_ready, 0);
    chk({tag, "_done_early"}, done, 0);
    step();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_rdy"}, in_ready, 1);
    chk({tag, "_final_cnt"}, match_count, cnt);
    final_cnt = int'(match_count);
    step();
    chk({tag, "_done_once"}, done, 0);
    chk({tag, "_cnt_hold"}, match_count, cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc;
    reset_n = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_load = 1'b0;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    m_pat = 0; m_len = 1;
    repeat (3) step();
    chk("rst_rdy", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pulse", match_pulse, 0);
    chk("rst_cnt", match_count, 0);
    reset_n = 1'b1;
    step();

    load_cfg(4'b1011, 3'd4);
    fw = '{8'b1011_0110};
    run_frame("tp1", 0, fc);
    chk("tp1_spec", fc, OVERLAP ? 2 : 1);

    load_cfg(4'b0101, 3'd3);
    fw = '{8'hAA};
    run_frame("tp2", 0, fc);
    chk("tp2_spec", fc, OVERLAP ? 3 : 2);

    load_cfg(4'b1011, 3'd4);
    fw = '{8'h01, 8'h60};
    run_frame("tp3", 0, fc);
    chk("tp3_spec", fc, 1);

    load_cfg(4'b0001, 3'd1);
    fw = '{8'hFF, 8'hFF, 8'hFF};
    run_frame("tp4", 0, fc);
    chk("tp4_sat", fc, 15);
    load_cfg(4'b0001, 3'd0);
    run_frame("tp4_len0", 0, fc);
    chk("tp4_len0_sat", fc, 15);

    load_cfg(4'b1011, 3'd4);
    fw = '{8'b1011_0110};
    run_frame("tp5_cfg_glitch", 1, fc);
    chk("tp5_spec", fc, OVERLAP ? 2 : 1);

    load_cfg(4'b0110, 3'd7);
    fw = '{8'b0110_1101, 8'b1011_0110};
    run_frame("clamp_hi", 0, fc);

    // Non-last word with no follower: frame abandoned, history dropped.
    load_cfg(4'b1011, 3'd4);
    in_valid = 1'b1; in_data = 8'h05; in_last = 1'b0;
    step();
    in_valid = 1'b0;
    repeat (DATA_W - 1) step();
    chk("nolast_busy_mid", busy, 1);
    step();
    chk("nolast_busy", busy, 0);
    chk("nolast_rdy", in_ready, 1);
    step();
    chk("nolast_no_done", done, 0);
    fw = '{8'h80};
    run_frame("fresh_hist", 0, fc);
    chk("fresh_hist_spec", fc, 0);

    // Asynchronous reset mid-word.
    in_valid = 1'b1; in_data = 8'b1011_0110; in_last = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rdy", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnt", match_count, 0);
    chk("mid_rst_pulse", match_pulse, 0);
    chk("mid_rst_done", done, 0);
    step();
    reset_n = 1'b1;
    m_pat = 0; m_len = 1;
    for (int i = 0; i < 4; i++) begin
      chk("mid_rst_no_done", done, 0);
      step();
    end
    fw = '{8'h0F};
    run_frame("post_rst_default_cfg", 0, fc);
    chk("post_rst_spec", fc, 4);

    for (int r = 0; r < 25; r++) begin
      int nw;
      load_cfg(PAT_W'($urandom), LEN_W'($urandom_range(0, 7)));
      nw = $urandom_range(1, 3);
      fw = {};
      for (int i = 0; i < nw; i++) fw.push_back(DATA_W'($urandom));
      run_frame("rand", ($urandom_range(0, 3) == 0), fc);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
